// File: rtl/age_ranker.sv
// Age-ordered ranking of NUM_PORTS flits by odd-even transposition sort.
// Ports: clk/reset(sync, low), start/in_* capture, out_ready; busy/out_valid/ranked_* result.
module age_ranker #(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 8,
    parameter int AGE_W     = 8,
    localparam int IDX_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [NUM_PORTS-1:0]        in_valid,
    input  logic [NUM_PORTS*AGE_W-1:0]  in_age,
    input  logic [NUM_PORTS*DATA_W-1:0] in_data,
    input  logic                        out_ready,
    output logic                        busy,
    output logic                        out_valid,
    output logic [NUM_PORTS*DATA_W-1:0] ranked_data,
    output logic [NUM_PORTS*IDX_W-1:0]  ranked_port,
    output logic [NUM_PORTS-1:0]        ranked_valid
);

    localparam int PH_W = $clog2(NUM_PORTS + 1);

    typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;

    state_t            state_q, state_d;
    logic [PH_W-1:0]   phase_q, phase_d;

    logic              sv_q [NUM_PORTS];
    logic              sv_d [NUM_PORTS];
    logic [AGE_W-1:0]  sa_q [NUM_PORTS];
    logic [AGE_W-1:0]  sa_d [NUM_PORTS];
    logic [DATA_W-1:0] sd_q [NUM_PORTS];
    logic [DATA_W-1:0] sd_d [NUM_PORTS];
    logic [IDX_W-1:0]  sp_q [NUM_PORTS];
    logic [IDX_W-1:0]  sp_d [NUM_PORTS];

    logic capture;

    // True when the upper slot (h) must move ahead of the lower slot (l).
    function automatic logic outranks(
        input logic             vh,
        input logic [AGE_W-1:0] ah,
        input logic [IDX_W-1:0] ph,
        input logic             vl,
        input logic [AGE_W-1:0] al,
        input logic [IDX_W-1:0] pl
    );
        if (vh != vl) return vh;
        if (vh && (ah != al)) return ah > al;
        return ph < pl;
    endfunction

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        sv_d    = sv_q;
        sa_d    = sa_q;
        sd_d    = sd_q;
        sp_d    = sp_q;
        capture = 1'b0;

        unique case (state_q)
            IDLE: capture = start;
            SORT: begin
                // Even phases pair (0,1),(2,3)..; odd phases (1,2),(3,4)..
                for (int i = 0; i < NUM_PORTS - 1; i++) begin
                    if (((i % 2) == int'(phase_q[0])) &&
                        outranks(sv_q[i+1], sa_q[i+1], sp_q[i+1],
                                 sv_q[i],   sa_q[i],   sp_q[i])) begin
                        sv_d[i]   = sv_q[i+1];
                        sv_d[i+1] = sv_q[i];
                        sa_d[i]   = sa_q[i+1];
                        sa_d[i+1] = sa_q[i];
                        sd_d[i]   = sd_q[i+1];
                        sd_d[i+1] = sd_q[i];
                        sp_d[i]   = sp_q[i+1];
                        sp_d[i+1] = sp_q[i];
                    end
                end
                if (phase_q == PH_W'(NUM_PORTS - 1)) begin
                    state_d = DONE;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    if (start) capture = 1'b1;
                    else       state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (capture) begin
            state_d = SORT;
            phase_d = '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                sv_d[p] = in_valid[p];
                sa_d[p] = in_age[p*AGE_W +: AGE_W];
                sd_d[p] = in_valid[p] ? in_data[p*DATA_W +: DATA_W] : '0;
                sp_d[p] = IDX_W'(p);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            phase_q <= '0;
            for (int k = 0; k < NUM_PORTS; k++) begin
                sv_q[k] <= 1'b0;
                sa_q[k] <= '0;
                sd_q[k] <= '0;
                sp_q[k] <= IDX_W'(k);
            end
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            sv_q    <= sv_d;
            sa_q    <= sa_d;
            sd_q    <= sd_d;
            sp_q    <= sp_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);

    always_comb begin
        ranked_data  = '0;
        ranked_port  = '0;
        ranked_valid = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            ranked_data[k*DATA_W +: DATA_W] = sd_q[k];
            ranked_port[k*IDX_W +: IDX_W]   = sp_q[k];
            ranked_valid[k]                 = sv_q[k];
        end
    end

endmodule

// File: doc/age_ranker.md
AGE_RANKER -- requirements
Module: age_ranker

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4: number of ranked inputs; legal range 1..16.
REQ-002 SHALL have parameter DATA_W, default 8: flit data width per port.
REQ-003 SHALL have parameter AGE_W, default 8: age width per port, unsigned.
REQ-004 SHALL have derived IDX_W = max(1, clog2(NUM_PORTS)).
REQ-005 clk  input  1  sole clock; all state changes on rising edge.
REQ-006 reset  input  1  synchronous, active-low reset.
REQ-007 start  input  1  request to capture inputs and begin ranking.
REQ-008 in_valid  input  NUM_PORTS  per-port valid; bit p belongs to port p.
REQ-009 in_age  input  NUM_PORTS*AGE_W  ages; port p at [p*AGE_W +: AGE_W].
REQ-010 in_data  input  NUM_PORTS*DATA_W  data; port p at [p*DATA_W +: DATA_W].
REQ-011 out_ready  input  1  consumer accepts the ranked result.
REQ-012 busy  output  1  high in SORT and DONE.
REQ-013 out_valid  output  1  ranked result available and stable.
REQ-014 ranked_data  output  NUM_PORTS*DATA_W  data by rank; slot 0 = highest priority at [DATA_W-1:0].
REQ-015 ranked_port  output  NUM_PORTS*IDX_W  source port index per slot, same packing.
REQ-016 ranked_valid  output  NUM_PORTS  valid flag per slot.

Function
REQ-017 SHALL use FSM states IDLE, SORT, DONE.
REQ-018 IDLE, start=1: capture in_valid/in_age/in_data and port index p into slot p; data of invalid ports captured as zero; next state SORT, phase counter=0.
REQ-019 IDLE, start=0: hold state and registers.
REQ-020 SORT SHALL perform one odd-even transposition phase per cycle: even phases compare slot pairs (0,1),(2,3)...; odd phases compare (1,2),(3,4)...
REQ-021 Pair (i,i+1) swaps all slot fields iff slot i+1 outranks slot i.
REQ-022 Rank order: valid before invalid; among valid, larger age first; equal ages, lower port index first; among invalid, lower port index first.
REQ-023 After exactly NUM_PORTS phases, state -> DONE and out_valid=1; out_valid rises NUM_PORTS edges after the capture edge.
REQ-024 start SHALL be ignored in SORT; inputs not re-sampled.
REQ-025 DONE: outputs held constant while out_ready=0 (indefinite back-pressure).
REQ-026 DONE, out_ready=1, start=0: next state IDLE, out_valid=0; ranked outputs retain last values.
REQ-027 DONE, out_ready=1, start=1: result transferred and new inputs captured in the same edge; next state SORT.
REQ-028 DONE, out_ready=0, start=1: start ignored.
REQ-029 in_valid all zero: SHALL still sort and reach DONE; ranked_valid=0, ranked_data=0, ranked_port in ascending order.
REQ-030 Age compare SHALL be full-width unsigned; no wrap-around interpretation.
REQ-031 NUM_PORTS=1: SORT lasts one cycle with no compares; output equals captured input.
REQ-032 Outputs SHALL be driven directly from registers; no combinational input-to-output path.

Reset
REQ-033 reset=0 at a rising edge SHALL force IDLE, phase=0, busy=0, out_valid=0, ranked_data=0, ranked_valid=0, ranked_port slot k = k, from any state including mid-SORT.
REQ-034 start while reset=0 SHALL be ignored; the first capture occurs on the first edge with reset=1 and start=1.

Verification (NUM_PORTS=4, DATA_W=8, AGE_W=8)
REQ-035 in_valid=4'hF, in_age=0x10_40_05_40, in_data=0xD3C2B1A0, start pulse -> out_valid 4 edges later; ranked_data=0xB1D3C2A0, ranked_port={1,3,2,0}, ranked_valid=4'hF.
REQ-036 in_valid=4'b1010, in_age=0x02_FF_01_FF, same data -> ranked_data=0x0000B1D3, ranked_port={2,0,1,3}, ranked_valid=4'b0011.
REQ-037 out_ready=0 for 10 cycles in DONE, start pulsed meanwhile -> outputs constant, busy=1; out_ready=1 -> IDLE next edge.
REQ-038 DONE with out_ready=1 and start=1 using new inputs -> out_valid drops one cycle, SORT begins, new result 4 edges later with no IDLE cycle.
REQ-039 reset=0 asserted on phase 2 of SORT -> next edge all outputs at reset values, state IDLE; subsequent start yields a correct result.
REQ-040 in_valid=0, start -> out_valid after 4 edges, ranked_valid=0, ranked_data=0, ranked_port={3,2,1,0}.
